axis_pkt_fifo: RTL
==================

Name: axis_pkt_fifo

Overview:
- Packet-aware AXI4-Stream FIFO that sits directly downstream of the stream IP's master port and feeds the DMA S2MM channel.
- Buffers data words together with their tlast flag.
- Optionally holds output until a whole packet is stored (store-and-forward).
- Forces a tlast on over-length packets so the DMA transfer always terminates.

Parameters:
- DATA_W, 32, stream data width.
- DEPTH, 32, FIFO entries; power of 2, at least 2.
- MAX_PKT, 32, maximum words per packet; 1 <= MAX_PKT <= DEPTH.
- STORE_FWD, 1, 1 = m_valid only when at least one complete packet is held; 0 = cut-through.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- s_data  in  DATA_W  input word (from IP m_data)
- s_valid  in  1  input valid
- s_tlast  in  1  input last word of packet
- s_ready  out  1  FIFO can accept a word
- m_data  out  DATA_W  output word (to DMA S2MM)
- m_valid  out  1  output valid
- m_tlast  out  1  output last word
- m_ready  in  1  DMA accepts word
- flush  in  1  synchronous clear of contents
- level  out  $clog2(DEPTH)+1  words stored
- pkt_cnt  out  $clog2(DEPTH)+1  complete packets stored
- len_err  out  1  sticky: a packet was truncated at MAX_PKT

Behaviour:
- Single clock domain; all state updates on posedge clk.
- Priority per cycle: rst > flush > push/pop.
- Reset or flush clears the following:
  - rd_ptr, wr_ptr and level go to 0.
  - pkt_cnt and the in-packet word counter go to 0.
  - len_err goes to 0.
  - Resulting outputs: s_ready=1, m_valid=0, m_tlast=0, m_data=0.
- A push or pop presented in the same cycle as rst or flush is discarded.
- Handshake rules:
  - push = s_valid & s_ready; pop = m_valid & m_ready.
  - s_ready = (level != DEPTH). When full, no write occurs even if a pop happens in the same cycle; s_ready rises the cycle after the pop.
  - m_valid, once high, stays high until pop (AXIS rule); m_data and m_tlast stay stable while m_valid & !m_ready.
- Storage and output timing:
  - Memory is DEPTH x (DATA_W+1); the stored tlast bit is stl.
  - Output is first-word-fall-through from mem[rd_ptr].
  - m_data and m_tlast are forced to 0 when m_valid=0.
  - Latency: a word pushed at edge N is presentable on m_data from cycle N+1.
- Output enable:
  - STORE_FWD=0: m_valid = (level != 0).
  - STORE_FWD=1: m_valid = (pkt_cnt != 0). Cut-through of partial packets is never allowed.
- Packet counting:
  - The in-packet counter wcnt increments on each push and resets to 0 on a push with stl=1.
  - stl = s_tlast | (wcnt == MAX_PKT-1).
  - If stl is set only because of the length limit, len_err is set (sticky until rst/flush). The following input words start a new packet.
- pkt_cnt update:
  - +1 on a push with stl=1.
  - -1 on a pop with m_tlast=1.
  - Both in the same cycle: unchanged.
- level update: +1 on push, -1 on pop, unchanged on both.
- Pointers wrap modulo DEPTH.
- Overflow and underflow are impossible by construction. Bench assertions check that level never exceeds DEPTH and never goes below 0.
- Store-and-forward deadlock cannot occur, because MAX_PKT <= DEPTH guarantees a tlast before full.

Decomposition:
- Shared package axis_pkg holds:
  - AXIS_DATA_W = 32
  - AXIS_PKT_WORDS = 32 (the IP buffer size)
  - the clog2-based count-width function
- One natural sub-module: axis_fifo_mem, a simple dual-port DEPTH x (DATA_W+1) array with synchronous write and asynchronous read.
- Pointer, count and handshake logic stays in axis_pkt_fifo.

Test Plan:
- Store-and-forward hold, STORE_FWD=1, m_ready=1:
  - Stimulus: push words 0..30 with s_tlast=0.
  - Required: m_valid stays 0 and level=31.
  - Stimulus: push word 31 with s_tlast=1.
  - Required: next cycle pkt_cnt=1 and m_valid=1. 32 pops return data 0..31 with m_tlast only on 31; then pkt_cnt=0 and level=0.
- Full/backpressure, m_ready=0:
  - Stimulus: push 32 words.
  - Required: level=32 and s_ready=0; a 33rd word is held and not written.
  - Stimulus: one pop.
  - Required: s_ready=1 on the following cycle, level=31.
- Forced tlast, MAX_PKT=32:
  - Stimulus: 40 words with s_tlast never set.
  - Required: word 31 is stored with tlast and len_err=1. Words 32..39 form a second, open packet, so pkt_cnt=1.
- Simultaneous push/pop, level=5, STORE_FWD=0:
  - Stimulus: push and pop in the same cycle for 10 cycles.
  - Required: level stays 5 and output order is preserved.
  - Stimulus: a cycle that pushes tlast and pops tlast together.
  - Required: pkt_cnt is unchanged.
- Flush mid-packet:
  - Stimulus: after 10 words of an open packet, assert flush together with s_valid.
  - Required: next cycle level=0, pkt_cnt=0, len_err=0, m_valid=0; the concurrent word is discarded.
- Reset mid-transfer:
  - Stimulus: rst=1 while m_valid=1 and m_ready=0.
  - Required: next cycle every output is at its reset value (s_ready=1, m_data=0, m_valid=0, m_tlast=0, level=0, pkt_cnt=0, len_err=0).

Source files
------------

// File: rtl/axis_pkg.sv
// Shared AXI4-Stream constants and sizing helpers for the stream/DMA path.
package axis_pkg;

    localparam int AXIS_DATA_W    = 32;
    localparam int AXIS_PKT_WORDS = 32;

    // Width needed to hold a count from 0 up to and including depth.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/axis_pkt_fifo_if.sv
// Stream-side signals of the packet FIFO: upstream s_* and downstream m_* channels.
interface axis_pkt_fifo_if
    import axis_pkg::*;
#(
    parameter int DATA_W = AXIS_DATA_W
);

    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_tlast;
    logic              s_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_tlast;
    logic              m_ready;

    // slave is the FIFO's own view; master is the surrounding source/sink.
    modport slave (
        input  s_data, s_valid, s_tlast, m_ready,
        output s_ready, m_data, m_valid, m_tlast
    );

    modport master (
        output s_data, s_valid, s_tlast, m_ready,
        input  s_ready, m_data, m_valid, m_tlast
    );

endinterface

// File: rtl/axis_fifo_mem.sv
// Simple dual-port storage array: synchronous write, asynchronous read.
module axis_fifo_mem #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/axis_pkt_fifo.sv
// Packet-aware AXIS FIFO between the stream IP and DMA S2MM: optional
// store-and-forward and forced tlast on over-length packets.
module axis_pkt_fifo
    import axis_pkg::*;
#(
    parameter int DATA_W    = AXIS_DATA_W,
    parameter int DEPTH     = 32,
    parameter int MAX_PKT   = AXIS_PKT_WORDS,
    parameter int STORE_FWD = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    axis_pkt_fifo_if.slave            axis,
    input  logic                      flush,
    output logic [cnt_w(DEPTH)-1:0]   level,
    output logic [cnt_w(DEPTH)-1:0]   pkt_cnt,
    output logic                      len_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);
    localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(MAX_PKT - 1);

    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] wcnt;
    logic [DATA_W:0] rd_word;
    logic push;
    logic pop;
    logic len_hit;
    logic stl;
    logic m_valid_int;
    logic mem_we;

    assign len_hit = (wcnt == LAST_IDX);
    assign stl     = axis.s_tlast | len_hit;

    // Store-and-forward only exposes data once a whole packet is buffered.
    assign m_valid_int = (STORE_FWD != 0) ? (pkt_cnt != '0) : (level != '0);

    assign axis.s_ready = (level != FULL_LVL);
    assign push         = axis.s_valid & axis.s_ready;
    assign pop          = m_valid_int & axis.m_ready;
    assign mem_we       = push & ~rst & ~flush;

    assign axis.m_valid = m_valid_int;
    assign axis.m_data  = m_valid_int ? rd_word[DATA_W-1:0] : '0;
    assign axis.m_tlast = m_valid_int & rd_word[DATA_W];

    axis_fifo_mem #(
        .WIDTH (DATA_W + 1),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_ptr),
        .wdata ({stl, axis.s_data}),
        .raddr (rd_ptr),
        .rdata (rd_word)
    );

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            level   <= '0;
            pkt_cnt <= '0;
            wcnt    <= '0;
            len_err <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
                wcnt   <= stl ? '0 : wcnt + CW'(1);
                // Only a length-limit cut counts as an error, not a real tlast.
                if (len_hit && !axis.s_tlast) begin
                    len_err <= 1'b1;
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end

            case ({push, pop})
                2'b10:   level <= level + CW'(1);
                2'b01:   level <= level - CW'(1);
                default: level <= level;
            endcase

            case ({push & stl, pop & axis.m_tlast})
                2'b10:   pkt_cnt <= pkt_cnt + CW'(1);
                2'b01:   pkt_cnt <= pkt_cnt - CW'(1);
                default: pkt_cnt <= pkt_cnt;
            endcase
        end
    end

endmodule
